// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared widths and tag type for the noise-reduction filter adder path
//
// Purpose: single home for the tap/sum widths and the shared adder latency so
// the arbiter, its result buffers and any client agree on one set of numbers.
// Ports: none (package).
package filt_pkg;

  localparam int DATA_W  = 16;              // one tap operand
  localparam int NTAP    = 9;               // 3x3 window
  localparam int SUM_W   = DATA_W + 4;      // 9 * (2^16-1) fits in 20 bits
  localparam int ADD_LAT = 1;               // register stages inside the shared adder
  localparam int REQ_W   = NTAP * DATA_W;   // packed window width

  // Travels alongside each operand set through the adder latency.
  typedef struct packed {
    logic v;    // a real request was issued in this slot
    logic id;   // requester that owns the result
  } tag_t;

endpackage

// File: rtl/sum_result_fifo.sv
// rtl/sum_result_fifo.sv - first-word-fall-through buffer for adder results
//
// Purpose: private result queue for one requester of the shared window adder.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the buffer)
//   wr_en       push wr_data this cycle
//   wr_data     SUM_W result from the shared adder
//   rd_en       pop the head this cycle (ignored when empty)
//   valid       buffer non-empty
//   data        head entry, 0 when empty
//   full        RES_DEPTH entries held
module sum_result_fifo #(
  parameter int SUM_W     = 20,
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SUM_W-1:0] wr_data,
  input  logic             rd_en,
  output logic             valid,
  output logic [SUM_W-1:0] data,
  output logic             full
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RES_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_DEPTH);

  logic [SUM_W-1:0] mem [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign valid = (count != '0);
  assign full  = (count == CNT_FULL);
  assign do_rd = rd_en && valid;
  // Upstream credit accounting keeps writes away from a full buffer; the
  // gate here only protects stored data if that contract is ever broken.
  assign do_wr = wr_en && !full;
  assign data  = valid ? mem[rd_ptr] : '0;

  // Storage is not reset: count==0 already hides any stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;   // idle, or write and pop together
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/adder_tree_arbiter.sv
// rtl/adder_tree_arbiter.sv - round-robin time-sharing of one 9-tap window adder between two requesters
//
// Purpose: grants the external pipelined adder to the smoothing path (0) or
// the edge/variance path (1), tags each issue through the adder latency and
// steers the sum into that requester's result buffer. A per-requester credit
// (buffered + in flight) stops issue before a buffer could overflow.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   reqN_valid/data     window request (tap k at [k*DATA_W +: DATA_W])
//   reqN_ready          request N accepted this cycle (equals its grant)
//   resN_valid/sum      head of result buffer N (sum 0 when empty)
//   resN_ready          consumer N pops the head
//   add_c               operands to the shared adder, 0 when idle
//   add_sum             adder result, ADD_LAT cycles after add_c
module adder_tree_arbiter
  import filt_pkg::*;
#(
  parameter int RES_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [REQ_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [REQ_W-1:0] req1_data,
  output logic             req1_ready,
  output logic             res0_valid,
  output logic [SUM_W-1:0] res0_sum,
  input  logic             res0_ready,
  output logic             res1_valid,
  output logic [SUM_W-1:0] res1_sum,
  input  logic             res1_ready,
  output logic [REQ_W-1:0] add_c,
  input  logic [SUM_W-1:0] add_sum
);

  localparam int OCC_W = $clog2(RES_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RES_DEPTH);

  logic [OCC_W-1:0] occ [2];       // buffered + in-flight results per requester
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic [1:0]       pop;
  logic [1:0]       wr_en;
  logic [1:0]       full;
  logic             last_grant;    // requester granted most recently
  tag_t             tag_pipe [ADD_LAT];
  tag_t             tag_out;

  // Occupancy is the registered value; a pop this cycle frees its slot only
  // from the next cycle on, which keeps the ready path free of res*_ready.
  assign eligible[0] = req0_valid && (occ[0] < OCC_MAX);
  assign eligible[1] = req1_valid && (occ[1] < OCC_MAX);

  // Grants are held off while reset is asserted so the readies read 0 even
  // with requesters already presenting windows.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (eligible == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = eligible;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    add_c = '0;
    if (grant[0]) begin
      add_c = req0_data;
    end else if (grant[1]) begin
      add_c = req1_data;
    end
  end

  assign pop[0] = res0_valid && res0_ready;
  assign pop[1] = res1_valid && res1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ[0]     <= '0;
      occ[1]     <= '0;
      last_grant <= 1'b1;          // requester 0 wins the first tie
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({grant[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + 1'b1;
          2'b01:   occ[i] <= occ[i] - 1'b1;
          default: occ[i] <= occ[i];
        endcase
      end
      if (|grant) begin
        last_grant <= grant[1];
      end
    end
  end

  // Tag shift register mirrors the adder's internal stages, so the last
  // stage describes the add_sum currently on the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= {|grant, grant[1]};
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  assign tag_out  = tag_pipe[ADD_LAT-1];
  assign wr_en[0] = tag_out.v && !tag_out.id;
  assign wr_en[1] = tag_out.v &&  tag_out.id;

  sum_result_fifo #(
    .SUM_W     (SUM_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_res0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en[0]),
    .wr_data (add_sum),
    .rd_en   (res0_ready),
    .valid   (res0_valid),
    .data    (res0_sum),
    .full    (full[0])
  );

  sum_result_fifo #(
    .SUM_W     (SUM_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_res1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en[1]),
    .wr_data (add_sum),
    .rd_en   (res1_ready),
    .valid   (res1_valid),
    .data    (res1_sum),
    .full    (full[1])
  );

  // Credits must never let a result arrive at a full buffer, and never
  // count beyond the buffer depth.
  a_credit_wr0: assert property (@(posedge clk) disable iff (!rst_n) wr_en[0] |-> !full[0]);
  a_credit_wr1: assert property (@(posedge clk) disable iff (!rst_n) wr_en[1] |-> !full[1]);
  a_occ_bound:  assert property (@(posedge clk) disable iff (!rst_n)
                                 (occ[0] <= OCC_MAX) && (occ[1] <= OCC_MAX));

endmodule
